// File: rtl/switch_lut_debounced_pkg.sv
// switch_lut_pkg: shared constants and helpers for the debounced switch LUT.
//   MAX_INPUTS : largest supported number of switch channels
//   cnt_width  : width of a debounce counter able to count 0..limit-1
package switch_lut_pkg;

  localparam int MAX_INPUTS = 4;

  function automatic int cnt_width(input int limit);
    return $clog2(limit);
  endfunction

endpackage

// File: rtl/switch_lut_debounced_if.sv
// switch_lut_debounced_if: truth-table load channel.
//   i_Cfg_Valid : one-cycle strobe, load i_Cfg_Table on this edge
//   i_Cfg_Table : new truth table, bit k = LED value for debounced vector k
// master drives a load, slave (the LUT block) receives it.
interface switch_lut_debounced_if #(
  parameter int N_INPUTS = 3
);

  logic                     i_Cfg_Valid;
  logic [2**N_INPUTS-1:0]   i_Cfg_Table;

  modport master (
    output i_Cfg_Valid,
    output i_Cfg_Table
  );

  modport slave (
    input  i_Cfg_Valid,
    input  i_Cfg_Table
  );

endinterface

// File: rtl/switch_lut_debounced_debounce.sv
// switch_debounce: one switch channel.
//   i_Clk    : system clock
//   i_Rst_L  : asynchronous active-low reset
//   i_Raw    : raw asynchronous switch level
//   o_Stable : debounced level (registered)
// A 2-flop synchroniser feeds a counter that runs only while the synced
// level disagrees with o_Stable. The counter tops out at LIMIT-1, where
// the output flips and the counter clears, so it cannot wrap.
module switch_debounce
  import switch_lut_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Raw,
  output logic o_Stable
);

  localparam int CNT_W = cnt_width(DEBOUNCE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic             sync_meta;
  logic             sync_level;
  logic [CNT_W-1:0] hold_cnt;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_meta  <= 1'b0;
      sync_level <= 1'b0;
      hold_cnt   <= '0;
      o_Stable   <= 1'b0;
    end else begin
      sync_meta  <= i_Raw;
      sync_level <= sync_meta;
      if (sync_level == o_Stable) begin
        hold_cnt <= '0;
      end else if (hold_cnt == CNT_LAST) begin
        // LIMIT consecutive disagreeing cycles: accept the new level
        o_Stable <= ~o_Stable;
        hold_cnt <= '0;
      end else begin
        hold_cnt <= hold_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/switch_lut_debounced.sv
// switch_lut_debounced: debounced switches indexing a loadable truth table
// that drives one registered LED.
//   i_Clk       : system clock, all state on rising edge
//   i_Rst_L     : asynchronous active-low reset
//   i_Switch    : raw bouncing switch levels, N_INPUTS bits
//   cfg         : truth-table load channel (slave side)
//   o_Debounced : debounced switch vector (registered)
//   o_LED       : registered LUT output
//   o_Change    : one-cycle pulse on the edge where o_LED toggles
// The LED is looked up from the registered table and registered vector, so
// a table load and a debounce flip on the same edge both show up together
// one edge later, with at most a single o_Change.
module switch_lut_debounced
  import switch_lut_pkg::*;
#(
  parameter int N_INPUTS       = 3,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter     LUT_INIT       = 8'hE8
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic [N_INPUTS-1:0]   i_Switch,
  switch_lut_debounced_if.slave cfg,
  output logic [N_INPUTS-1:0]   o_Debounced,
  output logic                  o_LED,
  output logic                  o_Change
);

  localparam int TBL_W = 2**N_INPUTS;

  if (N_INPUTS < 1 || N_INPUTS > MAX_INPUTS) begin : g_bad_inputs
    $error("switch_lut_debounced: N_INPUTS must be 1..%0d", MAX_INPUTS);
  end
  if (DEBOUNCE_LIMIT < 2) begin : g_bad_limit
    $error("switch_lut_debounced: DEBOUNCE_LIMIT must be >= 2");
  end
  if ($bits(LUT_INIT) != TBL_W) begin : g_bad_init
    $error("switch_lut_debounced: LUT_INIT width must be 2**N_INPUTS");
  end

  for (genvar i = 0; i < N_INPUTS; i++) begin : g_chan
    switch_debounce #(
      .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_debounce (
      .i_Clk   (i_Clk),
      .i_Rst_L (i_Rst_L),
      .i_Raw   (i_Switch[i]),
      .o_Stable(o_Debounced[i])
    );
  end

  logic [TBL_W-1:0] lut_q;
  logic             lut_bit;

  assign lut_bit = lut_q[o_Debounced];

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      lut_q    <= LUT_INIT;
      o_LED    <= LUT_INIT[0];
      o_Change <= 1'b0;
    end else begin
      if (cfg.i_Cfg_Valid) begin
        lut_q <= cfg.i_Cfg_Table;
      end
      o_LED    <= lut_bit;
      o_Change <= lut_bit ^ o_LED;
    end
  end

endmodule

// File: tb/tb_switch_lut_debounced.sv
module tb_switch_lut_debounced;

  localparam int N     = 3;
  localparam int LIMIT = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] sw;
  logic [N-1:0] o_Debounced;
  logic         o_LED;
  logic         o_Change;

  switch_lut_debounced_if #(.N_INPUTS(N)) cfg_if ();

  switch_lut_debounced #(
    .N_INPUTS      (N),
    .DEBOUNCE_LIMIT(LIMIT),
    .LUT_INIT      (8'hE8)
  ) dut (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .i_Switch   (sw),
    .cfg        (cfg_if),
    .o_Debounced(o_Debounced),
    .o_LED      (o_LED),
    .o_Change   (o_Change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each channel accepts a new level once the synced
  // level (raw input two edges back) has disagreed for LIMIT edges in a row.
  typedef struct {
    logic         led;
    logic [N-1:0] deb;
  } exp_t;

  exp_t         exp_q[$];
  logic [N-1:0] hist[$];
  int           run[N];
  logic [N-1:0] m_deb;
  logic [7:0]   m_lut;
  logic         m_led;
  logic         m_chg;

  task automatic model_reset();
    hist.delete();
    hist.push_back('0);
    hist.push_back('0);
    for (int i = 0; i < N; i++) run[i] = 0;
    m_deb = '0;
    m_lut = 8'hE8;
    m_led = 1'b0;
    m_chg = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic         led_n;
    logic [N-1:0] deb_n;
    logic [N-1:0] s;
    exp_t         e;
    led_n = m_lut[m_deb];
    deb_n = m_deb;
    hist.push_back(sw);
    s = hist.pop_front();
    for (int i = 0; i < N; i++) begin
      if (s[i] == m_deb[i]) run[i] = 0;
      else begin
        run[i] = run[i] + 1;
        if (run[i] == LIMIT) begin
          deb_n[i] = ~m_deb[i];
          run[i] = 0;
        end
      end
    end
    if (cfg_if.i_Cfg_Valid) m_lut = cfg_if.i_Cfg_Table;
    m_chg = (led_n != m_led);
    m_led = led_n;
    m_deb = deb_n;
    if (m_chg) begin
      e.led = led_n;
      e.deb = deb_n;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Monitor: compares every cycle and pops the scoreboard on each o_Change.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      chk("mon_led", 32'(o_LED), 32'(m_led));
      chk("mon_deb", 32'(o_Debounced), 32'(m_deb));
      chk("mon_chg", 32'(o_Change), 32'(m_chg));
      if (o_Change === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got change pulse expected none at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("sb_led", 32'(o_LED), 32'(e.led));
          chk("sb_deb", 32'(o_Debounced), 32'(e.deb));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int pulses;
    int flips;
    int led_hi;
    rst_n = 1'b1;
    sw = '0;
    cfg_if.i_Cfg_Valid = 1'b0;
    cfg_if.i_Cfg_Table = '0;

    // 1: asynchronous reset, no clock edge involved
    #2;
    sw = 3'b111;
    rst_n = 1'b0;
    #1;
    chk("rst_async_deb", 32'(o_Debounced), 32'h0);
    chk("rst_async_led", 32'(o_LED), 32'h0);
    chk("rst_async_chg", 32'(o_Change), 32'h0);
    cycles(4);
    chk("rst_hold_deb", 32'(o_Debounced), 32'h0);
    chk("rst_hold_led", 32'(o_LED), 32'h0);
    sw = 3'b000;
    cycles(1);
    rst_n = 1'b1;
    cycles(4);

    // 2: clean step 000 -> 011 after edge 0
    tick();
    sw = 3'b011;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 5) chk("step_deb_e5", 32'(o_Debounced), 32'h0);
      if (k == 6) chk("step_deb_e6", 32'(o_Debounced), 32'h3);
      if (k == 6) chk("step_led_e6", 32'(o_LED), 32'h0);
      if (k == 7) chk("step_led_e7", 32'(o_LED), 32'h1);
      if (k == 7) chk("step_chg_e7", 32'(o_Change), 32'h1);
      if (k == 8) chk("step_chg_e8", 32'(o_Change), 32'h0);
    end

    // 3: bounce on channel 0 shorter than LIMIT
    sw = 3'b000;
    cycles(12);
    chk("bounce_pre_led", 32'(o_LED), 32'h0);
    pulses = 0; flips = 0; led_hi = 0;
    for (int k = 0; k < 20 + LIMIT + 6; k++) begin
      if (k < 20) sw[0] = ((k / 2) % 2 == 0);
      else sw[0] = 1'b0;
      tick();
      if (o_Debounced[0]) flips++;
      if (o_Change) pulses++;
      if (o_LED) led_hi++;
    end
    chk("bounce_no_flip", 32'(flips), 32'h0);
    chk("bounce_no_chg", 32'(pulses), 32'h0);
    chk("bounce_no_led", 32'(led_hi), 32'h0);

    // 4: table load 8'h02 with switches at 001, then identical reload
    sw = 3'b001;
    cycles(12);
    chk("cfg_pre_led", 32'(o_LED), 32'h0);
    cfg_if.i_Cfg_Valid = 1'b1;
    cfg_if.i_Cfg_Table = 8'h02;
    tick();
    cfg_if.i_Cfg_Valid = 1'b0;
    cfg_if.i_Cfg_Table = 8'hFF;
    chk("cfg_led_t", 32'(o_LED), 32'h0);
    tick();
    chk("cfg_led_t1", 32'(o_LED), 32'h1);
    chk("cfg_chg_t1", 32'(o_Change), 32'h1);
    tick();
    chk("cfg_chg_t2", 32'(o_Change), 32'h0);
    cycles(3);
    cfg_if.i_Cfg_Valid = 1'b1;
    cfg_if.i_Cfg_Table = 8'h02;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      cfg_if.i_Cfg_Valid = 1'b0;
      if (o_Change) pulses++;
    end
    chk("cfg_reload_chg", 32'(pulses), 32'h0);
    chk("cfg_reload_led", 32'(o_LED), 32'h1);

    // 5: restore 8'hE8, then load 8'h01 on the same edge as the 001 -> 000 flip
    cfg_if.i_Cfg_Valid = 1'b1;
    cfg_if.i_Cfg_Table = 8'hE8;
    tick();
    cfg_if.i_Cfg_Valid = 1'b0;
    cycles(4);
    chk("sim_pre_led", 32'(o_LED), 32'h0);
    tick();
    sw = 3'b000;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (o_Change) pulses++;
      if (k == 6) chk("sim_deb_e6", 32'(o_Debounced), 32'h0);
      if (k == 6) chk("sim_led_e6", 32'(o_LED), 32'h0);
      if (k == 7) chk("sim_led_e7", 32'(o_LED), 32'h1);
      cfg_if.i_Cfg_Valid = (k == 5);
      cfg_if.i_Cfg_Table = 8'h01;
    end
    chk("sim_one_chg", 32'(pulses), 32'h1);

    // 6: reset two cycles into a 000 -> 011 step, table must revert to 8'hE8
    tick();
    sw = 3'b011;
    cycles(2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_led", 32'(o_LED), 32'h0);
    chk("mid_rst_deb", 32'(o_Debounced), 32'h0);
    cycles(2);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == LIMIT + 1) chk("mid_deb_before", 32'(o_Debounced), 32'h0);
      if (k == LIMIT + 2) chk("mid_deb_flip", 32'(o_Debounced), 32'h3);
      if (k == LIMIT + 3) chk("mid_led_e8tbl", 32'(o_LED), 32'h1);
    end

    // Randomised traffic checked by the model and scoreboard
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      if ($urandom_range(0, 999) == 0) begin
        #3;
        rst_n = 1'b0;
        @(posedge clk);
      end
      #1;
      rst_n = 1'b1;
      if ($urandom_range(0, 7) == 0) sw = 3'($urandom_range(0, 7));
      cfg_if.i_Cfg_Valid = ($urandom_range(0, 29) == 0);
      cfg_if.i_Cfg_Table = 8'($urandom_range(0, 255));
    end
    cfg_if.i_Cfg_Valid = 1'b0;
    cycles(12);
    chk("sb_drain", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
